// File: rtl/skid_pipe_reg.sv
// Two-entry skid pipeline register with flush and a stall counter.
// in_ready depends only on registered state, so no ready path runs combinationally through this stage.
module skid_pipe_reg #(
    parameter int                DATA_W    = 32,
    parameter int                CTRL_W    = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [CNT_W-1:0]  r_stall;

    logic w_main_vld;
    logic w_acc_in;
    logic w_acc_out;
    logic w_stall;

    assign w_main_vld = (r_state != S_EMPTY);
    assign in_ready   = (r_state != S_FULL);
    assign w_acc_in   = in_valid & in_ready;
    assign w_acc_out  = w_main_vld & out_ready;
    assign w_stall    = w_main_vld & ~out_ready;

    assign out_valid   = w_main_vld;
    assign out_data    = r_main_data;
    assign out_ctrl    = w_main_vld ? r_main_ctrl : '0;
    assign occupancy   = r_state;
    assign stall_count = r_stall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_EMPTY;
            r_main_data <= RESET_VAL;
            r_main_ctrl <= '0;
            r_skid_data <= RESET_VAL;
            r_skid_ctrl <= '0;
            r_stall     <= '0;
        end else begin
            if (w_stall && (r_stall != {CNT_W{1'b1}}))
                r_stall <= r_stall + CNT_W'(1);

            // Flush wins over every transition; data may keep stale values.
            if (flush) begin
                r_state     <= S_EMPTY;
                r_main_ctrl <= '0;
                r_skid_ctrl <= '0;
            end else begin
                unique case (r_state)
                    S_EMPTY: begin
                        if (w_acc_in) begin
                            r_state     <= S_ONE;
                            r_main_data <= in_data;
                            r_main_ctrl <= in_ctrl;
                        end
                    end
                    S_ONE: begin
                        if (w_acc_in && w_acc_out) begin
                            r_main_data <= in_data;
                            r_main_ctrl <= in_ctrl;
                        end else if (w_acc_in) begin
                            r_state     <= S_FULL;
                            r_skid_data <= in_data;
                            r_skid_ctrl <= in_ctrl;
                        end else if (w_acc_out) begin
                            r_state <= S_EMPTY;
                        end
                    end
                    S_FULL: begin
                        if (w_acc_out) begin
                            r_state     <= S_ONE;
                            r_main_data <= r_skid_data;
                            r_main_ctrl <= r_skid_ctrl;
                        end
                    end
                    default: r_state <= S_EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_skid_pipe_reg.sv
// Scoreboard bench for skid_pipe_reg: directed scenarios then random valid/ready traffic.
// A queue holds beats accepted but not yet delivered; occupancy/ready/valid follow from it.
module tb_skid_pipe_reg;

    localparam int                DATA_W = 32;
    localparam int                CTRL_W = 8;
    localparam int                CNT_W  = 2;
    localparam logic [DATA_W-1:0] RVAL   = 32'hDEAD_BEEF;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_count;

    skid_pipe_reg #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .RESET_VAL(RVAL),
        .CNT_W    (CNT_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .occupancy  (occupancy),
        .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } beat_t;

    beat_t q[$];
    int    m_stall = 0;
    int    n_checks = 0;
    int    n_errors = 0;
    int    n_sent = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp,
                     $time);
        end
    endtask

    // Inputs are already set; check outputs mid-cycle, update model, advance.
    task automatic tick();
        logic  exp_v;
        logic  rdy_m;
        beat_t b;
        #1;
        exp_v = (q.size() != 0);
        rdy_m = (q.size() < 2);
        check("out_valid", out_valid, exp_v);
        check("in_ready", in_ready, rdy_m);
        check("occupancy", occupancy, q.size());
        check("stall_count", stall_count, m_stall);
        if (!exp_v) check("ctrl_idle", out_ctrl, 0);
        if (exp_v && out_ready) begin
            b = q.pop_front();
            check("out_data", out_data, b.d);
            check("out_ctrl", out_ctrl, b.c);
        end
        if (exp_v && !out_ready && m_stall != 3) m_stall++;
        if (flush) q.delete();
        else if (in_valid && rdy_m) begin
            q.push_back({in_ctrl, in_data});
            n_sent++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                         input logic r);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = d[CTRL_W-1:0] ^ 8'h80;
        out_ready = r;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1234;
        in_ctrl   = 8'h55;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_ctrl", out_ctrl, 0);
        check("rst_occ", occupancy, 0);
        check("rst_ready", in_ready, 1);
        check("rst_data", out_data, RVAL);
        check("rst_stall", stall_count, 0);
        reset_n = 1'b1;
        drive(0, 0, 0);
        tick();

        // Back-to-back stream at full rate
        drive(1, 32'h11, 1); tick();
        drive(1, 32'h22, 1); tick();
        drive(1, 32'h33, 1); tick();
        drive(0, 0, 1);      tick();
        tick();

        // Fill both entries, then drain
        drive(1, 32'hA, 0); tick();
        drive(1, 32'hB, 0); tick();
        drive(0, 0, 0);     tick();
        drive(0, 0, 1);     tick();
        tick();
        tick();

        // Stall counter saturation while full
        drive(1, 32'h1A, 0); tick();
        drive(1, 32'h1B, 0); tick();
        drive(0, 0, 0);
        repeat (5) tick();
        check("stall_sat", stall_count, 3);

        // Flush while full with a new beat offered
        flush = 1'b1;
        drive(1, 32'hC, 0); tick();
        flush = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_occ", occupancy, 0);
        check("flush_ctrl", out_ctrl, 0);
        drive(0, 0, 1);
        repeat (3) tick();

        // Asynchronous reset while full
        drive(1, 32'h2A, 0); tick();
        drive(1, 32'h2B, 0); tick();
        drive(0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, RVAL);
        check("arst_stall", stall_count, 0);
        check("arst_occ", occupancy, 0);
        q.delete();
        m_stall = 0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        drive(1, 32'hD, 0); tick();
        drive(0, 0, 1);     tick();
        tick();

        // Random traffic against the reference queue
        n_sent = 0;
        while (n_sent < 10000) begin
            drive($urandom_range(0, 9) < 7, $urandom,
                  $urandom_range(0, 9) < 7);
            in_ctrl = 8'($urandom);
            flush = ($urandom_range(0, 499) == 0);
            tick();
        end
        flush = 1'b0;
        drive(0, 0, 1);
        repeat (4) tick();
        check("drain_occ", occupancy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks,
                 n_errors);
        $finish;
    end

endmodule
